// File: rtl/fp_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmp_unit
// Purpose  : Pipelined binary32 compare / min-max unit (FEQ, FLT, FLE, FMIN,
//            FMAX) with NV flag. Define FP_CMP_BYPASS_EN to drop the operand
//            stage and get single-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module fp_cmp_unit #(
    parameter int          TAG_W     = 5,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_op_feq  = 3'b000;
    localparam logic [2:0] c_op_flt  = 3'b001;
    localparam logic [2:0] c_op_fle  = 3'b010;
    localparam logic [2:0] c_op_fmin = 3'b011;
    localparam logic [2:0] c_op_fmax = 3'b100;
    localparam logic [31:0] c_neg_zero = 32'h80000000;

    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic             r_out_nv;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_s2_ready;
    logic             w_valid;
    logic [2:0]       w_op;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [TAG_W-1:0] w_tag;

    assign w_s2_ready = !r_out_valid || out_ready;

`ifdef FP_CMP_BYPASS_EN
    // Operands feed the compute logic straight from the request port.
    assign w_valid  = in_valid;
    assign w_op     = in_op;
    assign w_a      = in_a;
    assign w_b      = in_b;
    assign w_tag    = in_tag;
    assign in_ready = w_s2_ready;
`else
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;

    assign in_ready = !r_s1_valid || w_s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op  <= in_op;
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_tag <= in_tag;
            end
        end
    end

    assign w_valid = r_s1_valid;
    assign w_op    = r_s1_op;
    assign w_a     = r_s1_a;
    assign w_b     = r_s1_b;
    assign w_tag   = r_s1_tag;
`endif

    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_any_nan, w_any_snan;
    logic w_both_zero, w_sign_diff;
    logic w_mag_lt, w_mag_eq, w_mag_gt;
    logic w_lt, w_eq;

    assign w_a_nan     = (w_a[30:23] == 8'hFF) && (w_a[22:0] != 23'd0);
    assign w_b_nan     = (w_b[30:23] == 8'hFF) && (w_b[22:0] != 23'd0);
    assign w_a_snan    = w_a_nan && !w_a[22];
    assign w_b_snan    = w_b_nan && !w_b[22];
    assign w_any_nan   = w_a_nan || w_b_nan;
    assign w_any_snan  = w_a_snan || w_b_snan;
    assign w_both_zero = (w_a[30:0] == 31'd0) && (w_b[30:0] == 31'd0);
    assign w_sign_diff = w_a[31] ^ w_b[31];

    assign w_mag_lt = w_a[30:0] < w_b[30:0];
    assign w_mag_eq = w_a[30:0] == w_b[30:0];
    assign w_mag_gt = !w_mag_lt && !w_mag_eq;

    // With differing signs the negative operand is the lesser one.
    assign w_lt = !w_both_zero &&
                  (w_sign_diff ? w_a[31] : (w_a[31] ? w_mag_gt : w_mag_lt));
    assign w_eq = w_both_zero || (w_mag_eq && !w_sign_diff);

    logic [31:0] w_result;
    logic        w_nv;

    always_comb begin
        w_result = 32'd0;
        w_nv     = 1'b0;
        case (w_op)
            c_op_feq: begin
                w_result = {31'd0, !w_any_nan && w_eq};
                w_nv     = w_any_snan;
            end
            c_op_flt: begin
                w_result = {31'd0, !w_any_nan && w_lt};
                w_nv     = w_any_nan;
            end
            c_op_fle: begin
                w_result = {31'd0, !w_any_nan && (w_lt || w_eq)};
                w_nv     = w_any_nan;
            end
            c_op_fmin: begin
                w_nv = w_any_snan;
                if (w_a_nan && w_b_nan)            w_result = CANON_NAN;
                else if (w_a_nan)                  w_result = w_b;
                else if (w_b_nan)                  w_result = w_a;
                else if (w_both_zero && w_sign_diff) w_result = c_neg_zero;
                else                               w_result = (w_lt || w_eq) ? w_a : w_b;
            end
            c_op_fmax: begin
                w_nv = w_any_snan;
                if (w_a_nan && w_b_nan)            w_result = CANON_NAN;
                else if (w_a_nan)                  w_result = w_b;
                else if (w_b_nan)                  w_result = w_a;
                else if (w_both_zero && w_sign_diff) w_result = 32'd0;
                else                               w_result = w_lt ? w_b : w_a;
            end
            default: begin
                w_result = 32'd0;
                w_nv     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_nv     <= 1'b0;
            r_out_tag    <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= w_valid;
            if (w_valid) begin
                r_out_result <= w_result;
                r_out_nv     <= w_nv;
                r_out_tag    <= w_tag;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_nv     = r_out_nv;
    assign out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_cmp_unit
// Purpose  : Self-checking bench for fp_cmp_unit (default two-stage build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_cmp_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;

    fp_cmp_unit #(.TAG_W(TAG_W), .CANON_NAN(32'h7FC00000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_nv    (out_nv),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             nv;
        logic [31:0]      res;
    } sb_t;

    sb_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        last_acc;
    logic        dir_mode;
    logic [31:0] dir_res;
    logic        dir_nv;

    // Reference: map each float onto a signed integer line so ordering and
    // equality (+0 == -0) fall out of plain integer comparison.
    function automatic sb_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bit  an, bn, as, bs;
        int  ka, kb;
        sb_t r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        as = an && !a[22];
        bs = bn && !b[22];
        ka = a[31] ? -int'({1'b0, a[30:0]}) : int'({1'b0, a[30:0]});
        kb = b[31] ? -int'({1'b0, b[30:0]}) : int'({1'b0, b[30:0]});
        r.tag = tag;
        r.nv  = 1'b0;
        r.res = 32'd0;
        case (op)
            3'd0: begin r.res[0] = !(an || bn) && (ka == kb); r.nv = as || bs; end
            3'd1: begin r.res[0] = !(an || bn) && (ka <  kb); r.nv = an || bn; end
            3'd2: begin r.res[0] = !(an || bn) && (ka <= kb); r.nv = an || bn; end
            3'd3, 3'd4: begin
                r.nv = as || bs;
                if (an && bn)      r.res = 32'h7FC00000;
                else if (an)       r.res = b;
                else if (bn)       r.res = a;
                else if (ka == kb) r.res = (a[31] != b[31]) ? ((op == 3'd3) ? 32'h80000000 : 32'h0) : a;
                else               r.res = ((ka < kb) == (op == 3'd3)) ? a : b;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick();
        logic             stall;
        logic [31:0]      sres;
        logic             snv;
        logic [TAG_W-1:0] stag;
        sb_t              e;
        #1;
        last_acc = in_valid && in_ready && !rst;
        stall    = out_valid && !out_ready && !rst;
        sres = out_result; snv = out_nv; stag = out_tag;
        if (out_valid && out_ready && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (out_valid === 1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_output got tag=%0d res=%h, want no output", out_tag, out_result);
                end
            end else begin
                e = exp_q.pop_front();
                assert ({out_tag, out_nv, out_result} === e) else begin
                    errors++;
                    $error("FAIL result tag=%0d nv=%0d res=%h, want tag=%0d nv=%0d res=%h",
                           out_tag, out_nv, out_result, e.tag, e.nv, e.res);
                end
            end
        end
        if (last_acc) begin
            if (dir_mode) exp_q.push_back({in_tag, dir_nv, dir_res});
            else          exp_q.push_back(model(in_op, in_a, in_b, in_tag));
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
        if (stall) begin
            checks++;
            assert ({out_valid, out_result, out_nv, out_tag} === {1'b1, sres, snv, stag}) else begin
                errors++;
                $error("FAIL stall_hold got v=%0d res=%h nv=%0d tag=%0d, want v=1 res=%h nv=%0d tag=%0d",
                       out_valid, out_result, out_nv, out_tag, sres, snv, stag);
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic nv);
        int n;
        dir_mode = 1'b1; dir_res = res; dir_nv = nv;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_acc && n < 20);
        if (!last_acc) begin
            checks++;
            assert (last_acc === 1'b1) else begin
                errors++;
                $error("FAIL accept_timeout got in_ready=%0d, want accepted", in_ready);
            end
        end
        in_valid = 1'b0;
        dir_mode = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin tick(); n++; end
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL drain got %0d pending, want 0", exp_q.size());
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] other);
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 10)
            0: r = 32'h00000000;
            1: r = 32'h80000000;
            2: r = {r[31], 8'hFF, 1'b1, r[21:0]};
            3: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4: r = {r[31], 8'hFF, 23'd0};
            5: r = other;
            6: r = other ^ 32'h80000000;
            7: r = {r[31], 8'h7F, r[22:0]};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1; dir_mode = 1'b0; dir_res = '0; dir_nv = 1'b0; last_acc = 1'b0;
        @(negedge clk); tick(); tick();
        rst = 1'b0;

        checks++;
        assert ({out_valid, out_result, out_nv, out_tag, in_ready} === {1'b1 ^ 1'b1, 32'd0, 1'b0, 5'd0, 1'b1}) else begin
            errors++;
            $error("FAIL reset_state got v=%0d res=%h nv=%0d tag=%0d rdy=%0d, want 0/0/0/0/1",
                   out_valid, out_result, out_nv, out_tag, in_ready);
        end

        // FLT -1.0 < 1.0 with latency check
        send(3'd1, 32'hBF800000, 32'h3F800000, 5'd3, 32'd1, 1'b0);
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++; $error("FAIL latency_early got out_valid=%0d, want 0", out_valid);
        end
        tick();
        checks++;
        assert ({out_valid, out_tag} === {1'b1, 5'd3}) else begin
            errors++; $error("FAIL latency_2 got v=%0d tag=%0d, want v=1 tag=3", out_valid, out_tag);
        end
        drain();

        send(3'd0, 32'h80000000, 32'h00000000, 5'd4,  32'd1,        1'b0);
        send(3'd3, 32'h80000000, 32'h00000000, 5'd5,  32'h80000000, 1'b0);
        send(3'd4, 32'h80000000, 32'h00000000, 5'd6,  32'h00000000, 1'b0);
        send(3'd0, 32'h7FC00000, 32'h3F800000, 5'd7,  32'd0,        1'b0);
        send(3'd0, 32'h7F800001, 32'h3F800000, 5'd8,  32'd0,        1'b1);
        send(3'd2, 32'h7FC00000, 32'h3F800000, 5'd9,  32'd0,        1'b1);
        send(3'd4, 32'h7F800001, 32'h40000000, 5'd10, 32'h40000000, 1'b1);
        send(3'd3, 32'h7FC00000, 32'h7FC00000, 5'd11, 32'h7FC00000, 1'b0);
        send(3'd3, 32'hC0000000, 32'h3F800000, 5'd12, 32'hC0000000, 1'b0);
        send(3'd2, 32'h40400000, 32'h40400000, 5'd13, 32'd1,        1'b0);
        send(3'd6, 32'h3F800000, 32'h7F800001, 5'd14, 32'd0,        1'b0);
        drain();

        // Back-to-back FLE under a 3-cycle writeback stall
        begin
            logic [31:0] va[4];
            int k, n;
            va[0] = 32'h3F800000; va[1] = 32'hBF800000; va[2] = 32'h40000000; va[3] = 32'h00000000;
            out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd2; in_b = 32'h3F800000;
            k = 0; n = 0;
            while (k < 4 && n < 40) begin
                if (n == 3) out_ready = 1'b1;
                if (n == 2) begin
                    checks++;
                    assert (in_ready === 1'b0) else begin
                        errors++; $error("FAIL stall_in_ready got %0d, want 0", in_ready);
                    end
                end
                in_a = va[k]; in_tag = 5'(16 + k);
                tick();
                if (last_acc) k++;
                n++;
            end
            checks++;
            assert (k === 4) else begin
                errors++; $error("FAIL stall_accept got %0d accepted, want 4", k);
            end
            drain();
        end

        // Reset with two ops in flight
        out_ready = 1'b0;
        in_op = 3'd1; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'd20; in_valid = 1'b1;
        tick();
        in_tag = 5'd21;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        checks++;
        assert ({out_valid, out_result, out_nv, out_tag} === {1'b0, 32'd0, 1'b0, 5'd0}) else begin
            errors++;
            $error("FAIL reset_flush got v=%0d res=%h nv=%0d tag=%0d, want all 0",
                   out_valid, out_result, out_nv, out_tag);
        end
        for (int i = 0; i < 4; i++) tick();
        send(3'd4, 32'h3F800000, 32'hC0000000, 5'd22, 32'h3F800000, 1'b0);
        tick();
        checks++;
        assert ({out_valid, out_tag} === {1'b1, 5'd22}) else begin
            errors++; $error("FAIL post_reset got v=%0d tag=%0d, want v=1 tag=22", out_valid, out_tag);
        end
        drain();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom % 4) != 0;
                in_op    = 3'($urandom % 8);
                in_a     = pick($urandom);
                in_b     = pick(in_a);
                in_tag   = 5'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
